ssp_tx_ctrl: RTL and testbench

Transmit sequencer for the SSP serializer. Pulls words from the TX FIFO (show-ahead, external) and issues start_signal/TxData at frame boundaries. Supports back-to-back frames by prefetching the next word one cycle before the last bit, or a programmable idle gap between frames. Runs on SSPCLKOUT beside the serializer; at top level the serializer's CLEAR_B is tied to ~CLEAR.

---
 rtl/ssp_tx_ctrl_pkg.sv | 17 +
 rtl/ssp_tx_ctrl.sv | 118 +++++++++++
 tb/tb_ssp_tx_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ssp_tx_ctrl_pkg.sv
// Shared definitions for the SSP transmit sequencer: FSM encodings, the
// default frame width shared with the serializer, and a counter-width helper.
package ssp_tx_ctrl_pkg;

  localparam int SSP_N_DEFAULT = 8;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ARM      = 2'd1;
  localparam logic [1:0] ST_SHIFT    = 2'd2;
  localparam logic [1:0] ST_GAP_WAIT = 2'd3;

  // Bits needed for a down-counter that must hold values up to v-1 (at least 1).
  function automatic int cnt_width(input int v);
    return (v > 2) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/ssp_tx_ctrl.sv
// SSP transmit sequencer: pops words from a show-ahead TX FIFO and hands them
// to the serializer at frame boundaries, back-to-back or with an idle gap.
module ssp_tx_ctrl
  import ssp_tx_ctrl_pkg::*;
#(
  parameter int N     = SSP_N_DEFAULT,
  parameter int GAP   = 0,
  parameter int CNT_W = 16
) (
  input  logic             SSPCLKOUT,
  input  logic             CLEAR,
  input  logic             SSE,
  input  logic             fifo_empty,
  input  logic [N-1:0]     fifo_rdata,
  output logic             fifo_rd,
  output logic             start_signal,
  output logic [N-1:0]     TxData,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frames_sent
);

  localparam int BW = cnt_width(N);
  localparam int GW = cnt_width(GAP);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

  logic [1:0]       state_q, state_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [GW-1:0]    gapcnt_q, gapcnt_d;
  logic             pending_q, pending_d;
  logic [N-1:0]     cur_word_q, cur_word_d;
  logic [N-1:0]     hold_word_q, hold_word_d;
  logic [CNT_W-1:0] frames_q, frames_d;

  // Pops are suppressed while CLEAR is held so no word is lost to the reset.
  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    gapcnt_d     = gapcnt_q;
    pending_d    = pending_q;
    cur_word_d   = cur_word_q;
    hold_word_d  = hold_word_q;
    frames_d     = frames_q;
    fifo_rd      = 1'b0;
    start_signal = 1'b0;
    frame_done   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (SSE && !fifo_empty && !CLEAR) begin
          fifo_rd     = 1'b1;
          hold_word_d = fifo_rdata;
          state_d     = ST_ARM;
        end
      end
      ST_ARM: begin
        start_signal = 1'b1;
        cur_word_d   = hold_word_q;
        bitcnt_d     = BIT_LAST;
        state_d      = ST_SHIFT;
      end
      ST_SHIFT: begin
        bitcnt_d = bitcnt_q - BW'(1);
        if (bitcnt_q == BW'(1) && GAP == 0 && SSE && !fifo_empty && !CLEAR) begin
          fifo_rd     = 1'b1;
          hold_word_d = fifo_rdata;
          pending_d   = 1'b1;
        end
        if (bitcnt_q == '0) begin
          frame_done = 1'b1;
          frames_d   = frames_q + CNT_W'(1);
          if (pending_q) begin
            start_signal = 1'b1;
            cur_word_d   = hold_word_q;
            pending_d    = 1'b0;
            bitcnt_d     = BIT_LAST;
          end else if (GAP > 0) begin
            gapcnt_d = GAP_LOAD;
            state_d  = ST_GAP_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP_WAIT: begin
        if (gapcnt_q == '0) state_d = ST_IDLE;
        else gapcnt_d = gapcnt_q - GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign TxData      = start_signal ? hold_word_q : cur_word_q;
  assign busy        = (state_q != ST_IDLE);
  assign frames_sent = frames_q;

  always_ff @(posedge SSPCLKOUT) begin
    if (CLEAR) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= BIT_LAST;
      gapcnt_q    <= '0;
      pending_q   <= 1'b0;
      cur_word_q  <= '0;
      hold_word_q <= '0;
      frames_q    <= '0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      gapcnt_q    <= gapcnt_d;
      pending_q   <= pending_d;
      cur_word_q  <= cur_word_d;
      hold_word_q <= hold_word_d;
      frames_q    <= frames_d;
    end
  end

endmodule

// File: tb/tb_ssp_tx_ctrl.sv
// Self-checking bench for ssp_tx_ctrl: two instances (GAP=0 with a 4-bit
// frame counter, GAP=2 with a 16-bit one) compared against a frame-timeline model.
module tb_ssp_tx_ctrl;

  localparam int N = 8;

  logic       clk;
  logic       clear;
  logic       sse;
  logic       emptyA, emptyB;
  logic [7:0] rdataA, rdataB;
  logic       rdA, startA, busyA, doneA;
  logic       rdB, startB, busyB, doneB;
  logic [7:0] txA, txB;
  logic [3:0] fsA;
  logic [15:0] fsB;

  logic [7:0] fifoMem [2][64];
  logic [5:0] head [2];
  logic [5:0] tail [2];

  assign emptyA = (head[0] == tail[0]);
  assign emptyB = (head[1] == tail[1]);
  assign rdataA = fifoMem[0][head[0]];
  assign rdataB = fifoMem[1][head[1]];

  int checkCount;
  int passCount;
  int cyc;
  bit modelValid;

  bit         mActive [2];
  bit         mPending [2];
  int         mStart [2];
  int         mIdleAt [2];
  int         mCount [2];
  logic [7:0] mWord [2];
  logic [7:0] mPword [2];
  logic [7:0] mLast [2];

  ssp_tx_ctrl #(.N(N), .GAP(0), .CNT_W(4)) dutA (
    .SSPCLKOUT(clk), .CLEAR(clear), .SSE(sse),
    .fifo_empty(emptyA), .fifo_rdata(rdataA), .fifo_rd(rdA),
    .start_signal(startA), .TxData(txA), .busy(busyA),
    .frame_done(doneA), .frames_sent(fsA)
  );

  ssp_tx_ctrl #(.N(N), .GAP(2), .CNT_W(16)) dutB (
    .SSPCLKOUT(clk), .CLEAR(clear), .SSE(sse),
    .fifo_empty(emptyB), .fifo_rdata(rdataB), .fifo_rd(rdB),
    .start_signal(startB), .TxData(txB), .busy(busyB),
    .frame_done(doneB), .frames_sent(fsB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int gapOf(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  function automatic int maskOf(input int i);
    return (i == 0) ? 15 : 65535;
  endfunction

  function automatic logic instEmpty(input int i);
    return (i == 0) ? emptyA : emptyB;
  endfunction

  function automatic logic [7:0] instData(input int i);
    return (i == 0) ? rdataA : rdataB;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
  endtask

  // Expected outputs come from where the current frame sits on its timeline:
  // start at offset 0, prefetch window at N-1, last bit at N, then gap/idle.
  task automatic modelCheck(input int i, input string nm, input logic oRd, input logic oStart,
                            input logic [7:0] oTx, input logic oBusy, input logic oDone,
                            input logic [15:0] oFs);
    logic eRd, eStart, eBusy, eDone;
    logic [7:0] eTx;
    int k;
    eRd = 1'b0; eStart = 1'b0; eDone = 1'b0; eBusy = 1'b1; eTx = mLast[i];
    k = cyc - mStart[i];
    if (!mActive[i]) begin
      eBusy = (cyc < mIdleAt[i]);
      eRd   = !eBusy && sse && !instEmpty(i) && !clear;
    end else begin
      eTx = mWord[i];
      if (k == 0) eStart = 1'b1;
      if (k == N - 1) eRd = (gapOf(i) == 0) && sse && !instEmpty(i) && !clear;
      if (k == N) begin
        eDone = 1'b1;
        if (mPending[i]) begin
          eStart = 1'b1;
          eTx    = mPword[i];
        end
      end
    end
    checkOutput({nm, ".fifo_rd"}, 32'(oRd), 32'(eRd));
    checkOutput({nm, ".start_signal"}, 32'(oStart), 32'(eStart));
    checkOutput({nm, ".TxData"}, 32'(oTx), 32'(eTx));
    checkOutput({nm, ".busy"}, 32'(oBusy), 32'(eBusy));
    checkOutput({nm, ".frame_done"}, 32'(oDone), 32'(eDone));
    checkOutput({nm, ".frames_sent"}, 32'(oFs), 32'(mCount[i] & maskOf(i)));
  endtask

  task automatic modelUpdate(input int i);
    int k;
    k = cyc - mStart[i];
    if (clear) begin
      mActive[i] = 1'b0; mPending[i] = 1'b0; mCount[i] = 0;
      mLast[i] = 8'h00; mWord[i] = 8'h00; mStart[i] = 0; mIdleAt[i] = cyc + 1;
    end else if (!mActive[i]) begin
      if (cyc >= mIdleAt[i] && sse && !instEmpty(i)) begin
        mActive[i] = 1'b1;
        mStart[i]  = cyc + 1;
        mWord[i]   = instData(i);
      end
    end else begin
      if (k == N - 1 && gapOf(i) == 0 && sse && !instEmpty(i)) begin
        mPending[i] = 1'b1;
        mPword[i]   = instData(i);
      end
      if (k == N) begin
        mCount[i]++;
        if (mPending[i]) begin
          mWord[i]    = mPword[i];
          mPending[i] = 1'b0;
          mStart[i]   = cyc;
        end else begin
          mActive[i] = 1'b0;
          mLast[i]   = mWord[i];
          mIdleAt[i] = cyc + 1 + gapOf(i);
        end
      end
    end
  endtask

  task automatic pushWord(input logic [7:0] w);
    for (int i = 0; i < 2; i++) begin
      if (6'(tail[i] - head[i]) < 6'd60) begin
        fifoMem[i][tail[i]] = w;
        tail[i] = tail[i] + 6'd1;
      end
    end
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance model and FIFOs.
  task automatic applyStimulus(input logic sseV, input logic clrV);
    logic popA, popB;
    sse   = sseV;
    clear = clrV;
    @(negedge clk);
    if (modelValid) begin
      modelCheck(0, "A", rdA, startA, txA, busyA, doneA, {12'd0, fsA});
      modelCheck(1, "B", rdB, startB, txB, busyB, doneB, fsB);
    end
    popA = rdA;
    popB = rdB;
    modelUpdate(0);
    modelUpdate(1);
    if (clrV) modelValid = 1'b1;
    @(posedge clk);
    #1;
    if (popA === 1'b1 && head[0] != tail[0]) head[0] = head[0] + 6'd1;
    if (popB === 1'b1 && head[1] != tail[1]) head[1] = head[1] + 6'd1;
    cyc++;
  endtask

  initial begin
    checkCount = 0; passCount = 0; cyc = 0; modelValid = 1'b0;
    sse = 1'b1; clear = 1'b1;
    for (int i = 0; i < 2; i++) begin
      head[i] = '0; tail[i] = '0;
      mActive[i] = 1'b0; mPending[i] = 1'b0; mStart[i] = 0; mIdleAt[i] = 0;
      mCount[i] = 0; mWord[i] = '0; mPword[i] = '0; mLast[i] = '0;
    end

    // Reset held with a non-empty FIFO, then a single word.
    pushWord(8'hA5);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    for (int c = 0; c < 16; c++) applyStimulus(1'b1, 1'b0);

    // Three words queued together: back-to-back on A, gapped on B.
    pushWord(8'h81); pushWord(8'h3C); pushWord(8'hFF);
    for (int c = 0; c < 45; c++) applyStimulus(1'b1, 1'b0);

    // SSE drops mid-frame with three more words waiting.
    pushWord(8'h5A);
    applyStimulus(1'b1, 1'b0);
    pushWord(8'h11); pushWord(8'h22); pushWord(8'h33);
    for (int c = 0; c < 4; c++) applyStimulus(1'b1, 1'b0);
    for (int c = 0; c < 20; c++) applyStimulus(1'b0, 1'b0);
    checkOutput("A.fifo_level_after_sse_drop", 32'(6'(tail[0] - head[0])), 32'd3);
    checkOutput("B.fifo_level_after_sse_drop", 32'(6'(tail[1] - head[1])), 32'd3);

    // CLEAR at bitcnt 3, then sixteen frames to wrap the 4-bit counter on A.
    for (int c = 0; c < 6; c++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("A.frames_sent_after_clear", 32'(fsA), 32'd0);
    for (int w = 0; w < 14; w++) pushWord(8'($urandom_range(255, 0)));
    for (int c = 0; c < 230; c++) applyStimulus(1'b1, 1'b0);
    checkOutput("A.frames_sent_wrapped", 32'(fsA), 32'd0);
    checkOutput("B.frames_sent_16", 32'(fsB), 32'd16);

    // Randomized traffic, SSE toggling and occasional CLEAR.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(99, 0) < 35) pushWord(8'($urandom_range(255, 0)));
      applyStimulus(($urandom_range(99, 0) < 90) ? 1'b1 : 1'b0,
                    ($urandom_range(199, 0) == 0) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
